accel_sample_scheduler: RTL and testbench
=========================================

# accel_sample_scheduler

Periodic read sequencer for the accelerometer front end. On every sample tick it issues four SPI register reads in order: X, Y, Z, then temperature. It collects the results and presents them as one atomic set to `findAvgData` with a single-cycle `o_AVG_dataReady` strobe. It sits between the SPI master and the averager, and it flags SPI transactions that never complete.

## Interface
Parameters:
- `SAMPLE_PERIOD`, default 100000: clock cycles between sample-set starts (1 kHz at 100 MHz); minimum 64.
- `TIMEOUT`, default 4096: maximum cycles to wait for `i_SPI_done` after a start.
- `ADDR_X`, default 8'h0E: register address of X (low byte; the SPI master reads 2 bytes).
- `ADDR_Y`, default 8'h10: register address of Y.
- `ADDR_Z`, default 8'h12: register address of Z.
- `ADDR_T`, default 8'h14: register address of temperature.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-low reset.
- `i_SCHED_enable` in 1: run periodic sampling.
- `i_SCHED_clrError` in 1: clears `o_SCHED_error` (single-cycle pulse).
- `o_SPI_start` out 1: one-cycle request to the SPI master.
- `o_SPI_addr` out 8: register address; held stable from start until done.
- `i_SPI_done` in 1: one-cycle completion pulse from the SPI master.
- `i_SPI_rdData` in 16: read word ({high byte, low byte}); valid when `i_SPI_done` = 1.
- `o_ACCEL_X`, `o_ACCEL_Y`, `o_ACCEL_Z` out 12: last published samples.
- `o_ACCEL_T` out 19: last published temperature.
- `o_AVG_dataReady` out 1: one-cycle strobe to `findAvgData`.
- `o_SCHED_error` out 1: sticky timeout flag.
- `o_SCHED_overrun` out 1: one-cycle pulse when a tick is dropped.

## Operation
- **Reset (reset = 0, async):** all outputs 0, state `IDLE`, timers 0, shadow registers 0.
- **Tick timer:** counts 0 to `SAMPLE_PERIOD`-1 while enabled and wraps. The tick fires at the terminal count. The timer is held at 0 when `i_SCHED_enable` = 0.
- **FSM states:**
  - `IDLE`: stays here while enable = 0. Enable = 1 moves to `WAIT_TICK`.
  - `WAIT_TICK`: a tick moves to `ISSUE` with index = 0. Enable = 0 moves to `IDLE`.
  - `ISSUE`: pulses `o_SPI_start`, drives `o_SPI_addr` = ADDR[index], clears the timeout counter, then moves to `WAIT_DONE`.
  - `WAIT_DONE`:
    - On `i_SPI_done`: capture into shadow[index]. If index < 3, increment index and go to `ISSUE`; otherwise go to `PUBLISH`.
    - If the timeout counter reaches `TIMEOUT`: set `o_SCHED_error`, discard the shadows, and go to `WAIT_TICK` (or `IDLE` if enable = 0). No strobe is issued.
  - `PUBLISH`: copy all four shadows to the outputs in the same cycle and assert `o_AVG_dataReady` for 1 cycle. Then go to `WAIT_TICK` (or `IDLE` if enable = 0).
- **Width rules:**
  - X, Y and Z take `i_SPI_rdData[11:0]`.
  - T takes `i_SPI_rdData[11:0]` sign-extended to 19 bits.
  - Bits [15:12] are ignored.
- **Outputs between strobes:** `o_ACCEL_*` change only in `PUBLISH`. They are never partially updated.
- **Overrun:** a tick occurring in `ISSUE`, `WAIT_DONE` or `PUBLISH` is dropped and `o_SCHED_overrun` pulses. The timer keeps running.
- **Disable mid-sequence:** the current set completes (or times out). The block then goes to `IDLE`.
- **Error flag:** `i_SCHED_clrError` clears the flag. If clear and a new timeout coincide in the same cycle, set wins.
- **Spurious done:** `i_SPI_done` outside `WAIT_DONE` is ignored.

## Timing
- Let the tick be seen at cycle t, and let the SPI master answer L ≥ 1 cycles after start.
- Starts occur at t+1+k(L+1), for k = 0..3.
- `o_AVG_dataReady` is high at cycle t+4L+5. Outputs are valid in that same cycle and hold afterwards.
- The first tick occurs `SAMPLE_PERIOD` cycles after enable is seen in `WAIT_TICK`.
- Timeout: the error sets at `TIMEOUT` cycles after the start pulse.
- `o_SPI_addr` changes only in `ISSUE`.
- A reset asserted mid-sequence returns the block to the reset state immediately. There is no strobe and the error flag is cleared.

## Test plan
- **Nominal set.** Setup: `SAMPLE_PERIOD`=200, L=1, SPI returns 16'h0028, 16'h0073, 16'h00A3, 16'h0F00.
  - Addresses go out in the order 0E, 10, 12, 14.
  - One strobe with X=028, Y=073, Z=0A3, T=19'h7FF00.
  - Strobe lands exactly 9 cycles after the tick.
- **Periodicity.** Run 17 sets with `SAMPLE_PERIOD`=200 → 17 strobes spaced exactly 200 cycles apart, zero overruns.
- **Timeout.** Withhold `i_SPI_done` on the Y read, with `TIMEOUT`=50.
  - Error rises 50 cycles after start; no strobe and outputs unchanged.
  - The next tick completes normally.
  - `i_SCHED_clrError` then clears the flag.
- **Overrun.** Use `SAMPLE_PERIOD`=64, L=20 → `o_SCHED_overrun` pulses and every set still publishes complete.
- **Disable/reset mid-sequence.**
  - Deassert enable after the second start → the set finishes, one strobe, then `IDLE` with no further starts.
  - Assert reset during `WAIT_DONE` → all outputs go to 0 asynchronously.
- **Upper-nibble masking and spurious done.** `rdData`=16'hF800 for X gives X=800. A done pulse in `WAIT_TICK` is ignored.

Source files
------------

// File: rtl/accel_sample_scheduler.sv
// Periodic X/Y/Z/temperature SPI read sequencer feeding findAvgData.
// Publishes the four results atomically with a one-cycle strobe and flags SPI reads that never complete.
module accel_sample_scheduler #(
  parameter int         SAMPLE_PERIOD = 100000,
  parameter int         TIMEOUT       = 4096,
  parameter logic [7:0] ADDR_X        = 8'h0E,
  parameter logic [7:0] ADDR_Y        = 8'h10,
  parameter logic [7:0] ADDR_Z        = 8'h12,
  parameter logic [7:0] ADDR_T        = 8'h14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_SCHED_enable,
  input  logic        i_SCHED_clrError,
  output logic        o_SPI_start,
  output logic [7:0]  o_SPI_addr,
  input  logic        i_SPI_done,
  input  logic [15:0] i_SPI_rdData,
  output logic [11:0] o_ACCEL_X,
  output logic [11:0] o_ACCEL_Y,
  output logic [11:0] o_ACCEL_Z,
  output logic [18:0] o_ACCEL_T,
  output logic        o_AVG_dataReady,
  output logic        o_SCHED_error,
  output logic        o_SCHED_overrun
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int OW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE, PUBLISH} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_tick_cnt;
  logic [OW-1:0] r_to;
  logic [1:0]    r_idx;
  logic [7:0]    r_addr;
  logic          r_err, r_ovr;
  logic [11:0]   r_sh_x, r_sh_y, r_sh_z;
  logic [11:0]   r_out_x, r_out_y, r_out_z;
  logic [18:0]   r_out_t;
  logic          w_tick, w_busy, w_done_ok, w_timeout;
  logic [11:0]   w_raw;
  logic [3:0]    w_unused_hi;

  function automatic logic [7:0] f_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_X;
      2'd1:    return ADDR_Y;
      2'd2:    return ADDR_Z;
      default: return ADDR_T;
    endcase
  endfunction

  // Temperature is a signed 12-bit reading widened for the averager.
  function automatic logic signed [18:0] f_sext_t(input logic [11:0] raw);
    logic signed [11:0] v;
    v = signed'(raw);
    return 19'(v);
  endfunction

  assign w_raw       = i_SPI_rdData[11:0];
  assign w_unused_hi = i_SPI_rdData[15:12];
  assign w_tick      = i_SCHED_enable && (r_tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign w_busy      = (r_state == ISSUE) || (r_state == WAIT_DONE) || (r_state == PUBLISH);
  assign w_done_ok   = (r_state == WAIT_DONE) && i_SPI_done;
  // A done arriving on the last allowed cycle still counts as success.
  assign w_timeout   = (r_state == WAIT_DONE) && !i_SPI_done && (r_to >= OW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (i_SCHED_enable) w_next = WAIT_TICK;
      WAIT_TICK: begin
        if (!i_SCHED_enable) w_next = IDLE;
        else if (w_tick)     w_next = ISSUE;
      end
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (w_done_ok)      w_next = (r_idx == 2'd3) ? PUBLISH : ISSUE;
        else if (w_timeout) w_next = i_SCHED_enable ? WAIT_TICK : IDLE;
      end
      PUBLISH:   w_next = i_SCHED_enable ? WAIT_TICK : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_to       <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (!i_SCHED_enable || w_tick) r_tick_cnt <= '0;
      else                           r_tick_cnt <= r_tick_cnt + TW'(1);
      r_ovr <= w_tick && w_busy;
      if (w_timeout)             r_err <= 1'b1;
      else if (i_SCHED_clrError) r_err <= 1'b0;
      if (r_state == ISSUE)          r_to <= OW'(1);
      else if (r_state == WAIT_DONE) r_to <= r_to + OW'(1);
      // Address is updated on the edge into ISSUE and then held until done.
      if (r_state == WAIT_TICK && w_tick) begin
        r_idx  <= 2'd0;
        r_addr <= ADDR_X;
      end else if (w_done_ok && r_idx != 2'd3) begin
        r_idx  <= r_idx + 2'd1;
        r_addr <= f_addr(r_idx + 2'd1);
      end
    end
  end

  // Published outputs load on the edge into PUBLISH, so they are valid with the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_sh_z  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_out_z <= '0;
      r_out_t <= '0;
    end else if (w_timeout) begin
      r_sh_x <= '0;
      r_sh_y <= '0;
      r_sh_z <= '0;
    end else if (w_done_ok) begin
      case (r_idx)
        2'd0: r_sh_x <= w_raw;
        2'd1: r_sh_y <= w_raw;
        2'd2: r_sh_z <= w_raw;
        default: begin
          r_out_x <= r_sh_x;
          r_out_y <= r_sh_y;
          r_out_z <= r_sh_z;
          r_out_t <= f_sext_t(w_raw);
        end
      endcase
    end
  end

  assign o_SPI_start     = (r_state == ISSUE);
  assign o_SPI_addr      = r_addr;
  assign o_AVG_dataReady = (r_state == PUBLISH);
  assign o_SCHED_error   = r_err;
  assign o_SCHED_overrun = r_ovr;
  assign o_ACCEL_X       = r_out_x;
  assign o_ACCEL_Y       = r_out_y;
  assign o_ACCEL_Z       = r_out_z;
  assign o_ACCEL_T       = r_out_t;

endmodule

// File: tb/tb_accel_sample_scheduler.sv
// Scoreboard bench for accel_sample_scheduler: two instances (period 200 / timeout 50, and period 64 with slow SPI).
module tb_accel_sample_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en[2], clr[2], done[2];
  logic [15:0] rd[2];
  logic        start[2], rdy[2], err[2], ovr[2];
  logic [7:0]  addr[2];
  logic [11:0] ox[2], oy[2], oz[2];
  logic [18:0] ot[2];

  accel_sample_scheduler #(.SAMPLE_PERIOD(200), .TIMEOUT(50)) u_a (
    .clk(clk), .reset(rst_n), .i_SCHED_enable(en[0]), .i_SCHED_clrError(clr[0]),
    .o_SPI_start(start[0]), .o_SPI_addr(addr[0]), .i_SPI_done(done[0]), .i_SPI_rdData(rd[0]),
    .o_ACCEL_X(ox[0]), .o_ACCEL_Y(oy[0]), .o_ACCEL_Z(oz[0]), .o_ACCEL_T(ot[0]),
    .o_AVG_dataReady(rdy[0]), .o_SCHED_error(err[0]), .o_SCHED_overrun(ovr[0]));

  accel_sample_scheduler #(.SAMPLE_PERIOD(64)) u_b (
    .clk(clk), .reset(rst_n), .i_SCHED_enable(en[1]), .i_SCHED_clrError(clr[1]),
    .o_SPI_start(start[1]), .o_SPI_addr(addr[1]), .i_SPI_done(done[1]), .i_SPI_rdData(rd[1]),
    .o_ACCEL_X(ox[1]), .o_ACCEL_Y(oy[1]), .o_ACCEL_Z(oz[1]), .o_ACCEL_T(ot[1]),
    .o_AVG_dataReady(rdy[1]), .o_SCHED_error(err[1]), .o_SCHED_overrun(ovr[1]));

  typedef struct {
    int          id;
    logic [11:0] x, y, z;
    logic [18:0] t;
  } exp_t;

  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lat[2];
  logic [7:0]  drop[2];
  logic        spur[2];
  logic [15:0] rdv[2][4];
  int          cnt[2], nstart[2], nstrobe[2], novr[2];
  int          st_cyc[2][4], last_start_cyc[2], strobe_cyc[2], err_cyc[2];
  logic [7:0]  st_addr[2][4], cur_addr[2];
  logic        prev_err[2];

  logic [15:0] pat_rd[4][4];
  logic [11:0] pat_x[4], pat_y[4], pat_z[4];
  logic [18:0] pat_t[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load_rd(input int id, input int p);
    for (int j = 0; j < 4; j++) rdv[id][j] = pat_rd[p][j];
  endtask

  task automatic push_exp(input int id, input int p);
    exp_t e;
    e.id = id; e.x = pat_x[p]; e.y = pat_y[p]; e.z = pat_z[p]; e.t = pat_t[p];
    expq.push_back(e);
  endtask

  task automatic check_outs(input string name, input int id, input int p);
    check(name, {ox[id], oy[id], oz[id], ot[id]}, {pat_x[p], pat_y[p], pat_z[p], pat_t[p]});
  endtask

  task automatic wait_strobe(input int id, input int target, input int budget);
    int c = 0;
    while (nstrobe[id] < target && c < budget) begin
      tick_n(1);
      c++;
    end
    check("strobe_wait", 64'(nstrobe[id]), 64'(target));
  endtask

  task automatic wait_starts(input int id, input int target, input int budget);
    int c = 0;
    while (nstart[id] < target && c < budget) begin
      tick_n(1);
      c++;
    end
    check("start_wait", 64'(nstart[id]), 64'(target));
  endtask

  initial forever @(posedge clk) cyc++;

  // SPI master model: answers L cycles after each start, with optional withheld or spurious done.
  initial begin
    for (int i = 0; i < 2; i++) begin
      done[i] = 1'b0; rd[i] = '0; cnt[i] = 0; nstart[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            if (drop[i] == cur_addr[i]) begin
              drop[i] = 8'h00;
            end else begin
              int j;
              j = (int'(cur_addr[i]) - 14) / 2;
              done[i] = 1'b1;
              rd[i] = (j >= 0 && j < 4) ? rdv[i][j] : 16'hDEAD;
            end
          end
        end
        if (spur[i]) begin
          done[i] = 1'b1; rd[i] = 16'hFFFF; spur[i] = 1'b0;
        end
        if (start[i] === 1'b1) begin
          cur_addr[i] = addr[i];
          st_addr[i][nstart[i] % 4] = addr[i];
          st_cyc[i][nstart[i] % 4]  = cyc;
          last_start_cyc[i] = cyc;
          cnt[i] = lat[i];
          nstart[i]++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and tracks error/overrun events.
  initial begin
    for (int i = 0; i < 2; i++) begin
      nstrobe[i] = 0; novr[i] = 0; prev_err[i] = 1'b0; err_cyc[i] = 0; strobe_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rdy[i] === 1'b1) begin
          nstrobe[i]++;
          strobe_cyc[i] = cyc;
          if (expq.size() == 0) begin
            check("unexpected_strobe", 64'(i), 64'hFF);
          end else begin
            exp_t e;
            e = expq.pop_front();
            check("strobe_dut", 64'(i), 64'(e.id));
            check("accel_x", 64'(ox[i]), 64'(e.x));
            check("accel_y", 64'(oy[i]), 64'(e.y));
            check("accel_z", 64'(oz[i]), 64'(e.z));
            check("accel_t", 64'(ot[i]), 64'(e.t));
          end
        end
        if (ovr[i] === 1'b1) novr[i]++;
        if (err[i] === 1'b1 && prev_err[i] !== 1'b1) err_cyc[i] = cyc;
        prev_err[i] = err[i];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ns, base, s1;
    pat_rd[0] = '{16'h0028, 16'h0073, 16'h00A3, 16'h0F00};
    pat_rd[1] = '{16'hF800, 16'h1FFF, 16'h0001, 16'h07FF};
    pat_rd[2] = '{16'h0ABC, 16'hA123, 16'h5555, 16'hF800};
    pat_rd[3] = '{16'h0000, 16'h8000, 16'h0FFF, 16'h1FFF};
    pat_x = '{12'h028, 12'h800, 12'hABC, 12'h000};
    pat_y = '{12'h073, 12'hFFF, 12'h123, 12'h000};
    pat_z = '{12'h0A3, 12'h001, 12'h555, 12'hFFF};
    pat_t = '{19'h7FF00, 19'h007FF, 19'h7F800, 19'h7FFFF};
    rst_n = 1'b0;
    lat[0] = 1; lat[1] = 20;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; clr[i] = 1'b0; drop[i] = 8'h00; spur[i] = 1'b0;
    end
    tick_n(3);
    for (int i = 0; i < 2; i++) begin
      check("reset_ctrl", {start[i], addr[i], rdy[i], err[i], ovr[i]}, 64'h0);
      check("reset_data", {ox[i], oy[i], oz[i], ot[i]}, 64'h0);
    end
    rst_n = 1'b1;
    tick_n(2);

    // Nominal set followed by periodic sets with rotating data patterns.
    en[0] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      load_rd(0, k % 4);
      push_exp(0, k % 4);
      s1 = strobe_cyc[0];
      wait_strobe(0, k + 1, 450);
      if (k == 0) begin
        check("addr_order", {st_addr[0][0], st_addr[0][1], st_addr[0][2], st_addr[0][3]}, 64'h0E101214);
        for (int j = 1; j < 4; j++) check("start_spacing", 64'(st_cyc[0][j] - st_cyc[0][0]), 64'(2 * j));
        check("strobe_latency", 64'(strobe_cyc[0] - st_cyc[0][0]), 64'd8);
      end else begin
        check("strobe_period", 64'(strobe_cyc[0] - s1), 64'd200);
      end
      if (k == 5) begin
        spur[0] = 1'b1;
        tick_n(3);
        check_outs("spurious_done_hold", 0, 1);
      end
    end
    check("no_overrun", 64'(novr[0]), 64'd0);

    // Timeout on the Y read.
    ns = nstrobe[0];
    load_rd(0, 1);
    drop[0] = 8'h10;
    begin
      int c = 0;
      while (err[0] !== 1'b1 && c < 500) begin tick_n(1); c++; end
    end
    check("error_set", 64'(err[0]), 64'd1);
    check("error_latency", 64'(err_cyc[0] - last_start_cyc[0]), 64'd50);
    check("timeout_addr", 64'(cur_addr[0]), 64'h10);
    check("timeout_no_strobe", 64'(nstrobe[0]), 64'(ns));
    check_outs("timeout_outs_hold", 0, 0);
    load_rd(0, 2);
    push_exp(0, 2);
    wait_strobe(0, ns + 1, 300);
    check("error_sticky", 64'(err[0]), 64'd1);
    clr[0] = 1'b1;
    tick_n(1);
    clr[0] = 1'b0;
    check("error_cleared", 64'(err[0]), 64'd0);

    // Disable after the second start: set completes, then no further starts.
    load_rd(0, 3);
    push_exp(0, 3);
    base = nstart[0];
    wait_starts(0, base + 2, 300);
    en[0] = 1'b0;
    wait_strobe(0, ns + 2, 50);
    tick_n(450);
    check("disable_starts", 64'(nstart[0]), 64'(base + 4));
    check("disable_strobes", 64'(nstrobe[0]), 64'(ns + 2));

    // Overrun: 64-cycle period with a 20-cycle SPI latency.
    load_rd(1, 2);
    for (int k = 0; k < 3; k++) push_exp(1, 2);
    en[1] = 1'b1;
    wait_strobe(1, 1, 300);
    s1 = strobe_cyc[1];
    wait_strobe(1, 2, 300);
    check("overrun_period", 64'(strobe_cyc[1] - s1), 64'd128);
    s1 = strobe_cyc[1];
    wait_strobe(1, 3, 300);
    check("overrun_period", 64'(strobe_cyc[1] - s1), 64'd128);
    check("overrun_count", 64'(novr[1]), 64'd3);

    // Asynchronous reset while waiting for an SPI answer.
    base = nstart[1];
    wait_starts(1, base + 1, 200);
    tick_n(5);
    #2;
    rst_n = 1'b0;
    en[1] = 1'b0;
    #1;
    check("async_reset_ctrl", {start[1], addr[1], rdy[1], err[1], ovr[1]}, 64'h0);
    check("async_reset_data", {ox[1], oy[1], oz[1], ot[1]}, 64'h0);
    tick_n(3);
    rst_n = 1'b1;
    tick_n(100);
    check("reset_no_strobe", 64'(nstrobe[1]), 64'd3);
    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
